// File: rtl/stack_sdram_bridge.sv
// 16-bit stack-CPU bus to 32-bit word-addressed SDRAM slave bridge with bounded acknowledge wait.
// Define STACK_SDRAM_BRIDGE_WPOST_EN to post writes (early cpu_done, sticky status_werr on timeout).
module stack_sdram_bridge #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic        status_werr,
  output logic [15:0] sdram_address,
  output logic [3:0]  sdram_byte_enable,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic [31:0] sdram_write_data,
  input  logic        sdram_acknowledge,
  input  logic [31:0] sdram_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] cnt;
  logic        lane;
  logic        expire;

  // Acknowledge wins over expiry when both land on the same cycle.
  assign expire = (cnt == TMO) && !sdram_acknowledge;

`ifndef STACK_SDRAM_BRIDGE_WPOST_EN
  assign status_werr = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      lane              <= 1'b0;
      cpu_ready         <= 1'b1;
      cpu_done          <= 1'b0;
      cpu_err           <= 1'b0;
      cpu_rdata         <= '0;
      sdram_address     <= '0;
      sdram_byte_enable <= '0;
      sdram_read        <= 1'b0;
      sdram_write       <= 1'b0;
      sdram_write_data  <= '0;
`ifdef STACK_SDRAM_BRIDGE_WPOST_EN
      status_werr       <= 1'b0;
`endif
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_ready         <= 1'b0;
            cnt               <= '0;
            lane              <= cpu_addr[0];
            sdram_address     <= cpu_addr[16:1];
            sdram_byte_enable <= cpu_addr[0] ? 4'b1100 : 4'b0011;
            sdram_write_data  <= {cpu_wdata, cpu_wdata};
            if (cpu_we) begin
              sdram_write <= 1'b1;
              state       <= WR;
`ifdef STACK_SDRAM_BRIDGE_WPOST_EN
              cpu_done    <= 1'b1;
`endif
            end else begin
              sdram_read <= 1'b1;
              state      <= RD;
            end
          end
        end
        RD: begin
          if (sdram_acknowledge) begin
            sdram_read <= 1'b0;
            cpu_rdata  <= lane ? sdram_read_data[31:16] : sdram_read_data[15:0];
            cpu_done   <= 1'b1;
            state      <= RESP;
          end else if (expire) begin
            sdram_read <= 1'b0;
            cpu_rdata  <= '0;
            cpu_done   <= 1'b1;
            cpu_err    <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WR: begin
          if (sdram_acknowledge || expire) begin
            sdram_write <= 1'b0;
`ifdef STACK_SDRAM_BRIDGE_WPOST_EN
            // The CPU already saw completion; only the sticky flag records a timeout.
            cpu_ready   <= 1'b1;
            state       <= IDLE;
            if (expire) status_werr <= 1'b1;
`else
            cpu_done    <= 1'b1;
            cpu_err     <= expire;
            state       <= RESP;
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_sdram_bridge.md
# stack_sdram_bridge

Bridges the 16-bit stack-processor data bus onto the 32-bit SDRAM slave port of the HPS system (`sdram_*`, word-addressed, acknowledge handshake), sitting directly upstream of it in the FPGA fabric. Each CPU halfword access becomes one SDRAM word transaction with byte enables. The slave request is held until acknowledged or until a bounded timeout expires. Optional write posting lets the CPU continue while a write completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum cycles a slave request is held without acknowledge before it is aborted; legal range 1..65535.

Ports. One clock; reset is asynchronous and active-low.
- `clk_clk`  in  1  system clock; all logic is on the rising edge.
- `reset_reset_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU request valid.
- `cpu_we`  in  1  1 = write, 0 = read; qualified by `cpu_req`.
- `cpu_addr`  in  17  halfword address.
- `cpu_wdata`  in  16  write data.
- `cpu_ready`  out  1  bridge can accept a request; a request transfers on `cpu_req && cpu_ready`.
- `cpu_done`  out  1  one-cycle pulse marking request completion.
- `cpu_err`  out  1  valid with `cpu_done`; 1 = the request timed out.
- `cpu_rdata`  out  16  read data; valid with `cpu_done` for reads, held until the next `cpu_done`.
- `status_werr`  out  1  sticky flag: a posted write timed out.
- `sdram_address`  out  16  word address.
- `sdram_byte_enable`  out  4  byte lanes.
- `sdram_read`  out  1  read strobe, held until acknowledge.
- `sdram_write`  out  1  write strobe, held until acknowledge.
- `sdram_write_data`  out  32  write data.
- `sdram_acknowledge`  in  1  slave completion.
- `sdram_read_data`  in  32  read data; valid when `sdram_acknowledge` = 1.

## Operation
- FSM states:
  - IDLE: `cpu_ready` = 1. On accept, latch the request and go to RD or WR.
  - RD or WR: drive the strobe. On acknowledge, go to RESP. On timeout, go to RESP with the error flagged.
  - RESP: one cycle; pulse `cpu_done`, then return to IDLE.
- Address mapping:
  - `sdram_address = cpu_addr[16:1]`.
  - `sdram_byte_enable` = 4'b0011 when `cpu_addr[0]` = 0; 4'b1100 when `cpu_addr[0]` = 1.
- Write data: `sdram_write_data = {cpu_wdata, cpu_wdata}`.
- Read data: `cpu_rdata` takes `sdram_read_data[15:0]` or `[31:16]` according to the latched `cpu_addr[0]`. It is captured on the acknowledge cycle.
- Timeout counter:
  - 16-bit; cleared on entering RD or WR; increments each cycle without acknowledge.
  - When the count equals `TIMEOUT_CYCLES` and no acknowledge is present, drop the strobe and go to RESP with `cpu_err` = 1.
  - A timed-out read returns `cpu_rdata` = 0.
  - Acknowledge on the same cycle as expiry counts as success.
- `sdram_acknowledge` is ignored in IDLE and RESP, so a late acknowledge after an abort has no effect.
- `cpu_req` while `cpu_ready` = 0 is not accepted; the CPU holds it.
- `status_werr` is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: `cpu_ready` = 1 once out of reset; all other outputs 0, including `cpu_rdata`, all `sdram_*` outputs and `status_werr`.
- Reset mid-transaction: strobes drop immediately (asynchronously) and the FSM returns to IDLE with no `cpu_done`.
- Accept at cycle N: the strobe, address, byte enables and data are valid from N+1 and stay stable while the strobe is high.
- Acknowledge sampled at cycle M: the strobe is low at M+1, `cpu_done` pulses at M+1, and `cpu_ready` = 1 at M+2.
- Minimum request-to-done latency is 2 cycles (zero-wait slave); sustained throughput is one access per 3 cycles.
- Timeout: the strobe is high for `TIMEOUT_CYCLES`+1 cycles, then `cpu_done` and `cpu_err` are 1 on the following cycle.

## Configuration
- Macro: `STACK_SDRAM_BRIDGE_WPOST_EN`.
- Defined (posted writes):
  - A write accepted at N pulses `cpu_done` at N+1 with `cpu_err` = 0 while the WR phase proceeds.
  - No RESP cycle for writes; `cpu_ready` = 1 the cycle after acknowledge or timeout.
  - A posted-write timeout sets `status_werr`.
  - Reads always use the unposted path.
- Undefined:
  - Writes complete through RESP like reads; `cpu_err` reports the write timeout.
  - `status_werr` is tied to 0.

## Test plan
- Read of `cpu_addr` = 17'h00005, slave acknowledges 1 cycle after the strobe with `sdram_read_data` = 32'hBEEF_1234 -> `sdram_address` = 16'h0002, byte enables 4'b1100, `cpu_rdata` = 16'hBEEF, `cpu_err` = 0.
- Write of 16'hA5A5 to `cpu_addr` = 17'h1FFFE -> `sdram_address` = 16'hFFFF, byte enables 4'b0011, `sdram_write_data` = 32'hA5A5A5A5, one `cpu_done`.
- `TIMEOUT_CYCLES` = 4, no acknowledge -> strobe high exactly 5 cycles, then `cpu_done` with `cpu_err` = 1 and `cpu_rdata` = 0; a late acknowledge 3 cycles later is ignored.
- Acknowledge on exactly the expiry cycle -> success, `cpu_err` = 0, data captured.
- Assert `reset_reset_n` low while a read waits for acknowledge -> `sdram_read` = 0 immediately, no `cpu_done`, `cpu_ready` = 1 after release.
- With `STACK_SDRAM_BRIDGE_WPOST_EN` defined: write, then a read issued next cycle -> `cpu_done` at N+1, read stalled by `cpu_ready` = 0 until the write is acknowledged; a timed-out posted write sets `status_werr` = 1.
